fifo_generator: RTL and testbench

FIFO_GENERATOR -- requirements
Module: fifo_generator

---
 rtl/fifo_pkg.sv | 11 +
 rtl/fifo_ram.sv | 31 +++
 rtl/fifo_generator.sv | 86 ++++++++
 tb/tb_fifo_generator.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO: default geometry and the occupancy-count width.
package fifo_pkg;
  localparam int DATA_W_DEF = 14;
  localparam int ADDR_W_DEF = 4;
  localparam int CNT_W_DEF  = ADDR_W_DEF + 1;

  // Count must hold 0..2**addr_w inclusive, hence one extra bit.
  function automatic int cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: synchronous write port, registered read port with
// write-first bypass so a same-address write is visible on the read register.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end
endmodule

// File: rtl/fifo_generator.sv
// Synchronous FIFO: pointer, count and flag logic around fifo_ram.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is standard mode.
module fifo_generator
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   data_count,
  output logic              overflow,
  output logic              underflow
);
  localparam int CNT_W = cnt_w(ADDR_W);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2**ADDR_W);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] ram_raddr;
  logic              ram_re;
  logic              wr_acc;
  logic              rd_acc;
  logic [CNT_W-1:0]  count_next;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    count_next = data_count;
    if (wr_acc && !rd_acc) begin
      count_next = data_count + CNT_W'(1);
    end else if (rd_acc && !wr_acc) begin
      count_next = data_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_W'(1);
      data_count <= count_next;
      empty      <= (count_next == '0);
      full       <= (count_next == DEPTH);
      overflow   <= wr_en & full;
      underflow  <= rd_en & empty;
    end
  end

`ifdef FIFO_FWFT_EN
  // Read register always tracks the head: prefetch the next slot when popping.
  assign ram_re    = 1'b1;
  assign ram_raddr = rd_acc ? rd_ptr + ADDR_W'(1) : rd_ptr;
`else
  assign ram_re    = rd_acc;
  assign ram_raddr = rd_ptr;
`endif

  fifo_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_acc),
    .waddr(wr_ptr),
    .wdata(din),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(dout)
  );
endmodule

// File: tb/tb_fifo_generator.sv
// Self-checking bench for fifo_generator: a directed vector table for fill/drain,
// then queue-model-checked sequences for sliding window, rd/wr collisions, wrap and reset.
module tb_fifo_generator;
`ifdef FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] din = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [13:0] dout;
  logic        full;
  logic        empty;
  logic [4:0]  data_count;
  logic        overflow;
  logic        underflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [13:0] q[$];
  logic [13:0] m_dout = '0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [13:0] din;
    logic        chk_dout;
    logic [13:0] dout;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t tbl[35];

  fifo_generator #(.DATA_W(14), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .full(full), .empty(empty), .data_count(data_count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input bit w, input bit r, input int d, input bit cd,
                              input int ed, input int ec, input bit ef, input bit ee,
                              input bit eo, input bit eu);
    vec_t v;
    v.wr = w; v.rd = r; v.din = 14'(d); v.chk_dout = cd; v.dout = 14'(ed);
    v.count = 5'(ec); v.full = ef; v.empty = ee; v.ovf = eo; v.udf = eu;
    return v;
  endfunction

  task automatic check(input string name, input bit chk_dout, input logic [13:0] e_dout,
                       input logic [4:0] e_cnt, input logic e_full, input logic e_empty,
                       input logic e_ovf, input logic e_udf);
    logic [13:0] a_dout;
    a_dout = chk_dout ? dout : e_dout;
    n_checks++;
    if ({a_dout, data_count, full, empty, overflow, underflow} !==
        {e_dout, e_cnt, e_full, e_empty, e_ovf, e_udf}) begin
      n_errors++;
      $display("FAIL %s: got dout=%0d count=%0d full=%b empty=%b ovf=%b udf=%b, expected dout=%0d%s count=%0d full=%b empty=%b ovf=%b udf=%b",
               name, dout, data_count, full, empty, overflow, underflow,
               e_dout, chk_dout ? "" : "(any)", e_cnt, e_full, e_empty, e_ovf, e_udf);
    end else begin
      $display("%s: dout=%0d count=%0d full=%b empty=%b ovf=%b udf=%b ok",
               name, dout, data_count, full, empty, overflow, underflow);
    end
  endtask

  // One clock with the given request, then compare against the queue model.
  task automatic step(input logic w, input logic r, input logic [13:0] d, input string name);
    int sz;
    bit wa, ra, chk;
    wr_en = w; rd_en = r; din = d;
    @(posedge clk); #1;
    sz = q.size();
    wa = w && (sz < 16);
    ra = r && (sz > 0);
    if (ra) begin
      if (!FWFT) m_dout = q[0];
      q.delete(0);
    end
    if (wa) q.push_back(d);
    chk = 1'b1;
    if (FWFT) begin
      chk = (q.size() > 0);
      if (chk) m_dout = q[0];
    end
    check(name, chk, m_dout, 5'(q.size()), q.size() == 16, q.size() == 0, w && !wa, r && !ra);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_wr;
    bit w, r;

    // Fill: 16 writes, rejected 17th; drain: 16 reads, rejected 17th, then idle.
    for (int i = 0; i < 16; i++) tbl[i] = mk(1, 0, i, 1, 0, i + 1, i == 15, 0, 0, 0);
    tbl[16] = mk(1, 0, 99, 1, 0, 16, 1, 0, 1, 0);
    for (int k = 0; k < 16; k++)
      tbl[17 + k] = mk(0, 1, 0, FWFT ? (k < 15) : 1'b1, FWFT ? k + 1 : k, 15 - k, 0, k == 15, 0, 0);
    tbl[33] = mk(0, 1, 0, !FWFT, 15, 0, 0, 1, 0, 1);
    tbl[34] = mk(0, 0, 0, !FWFT, 15, 0, 0, 1, 0, 0);

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b1;
    #2 check("reset_async", 1, 0, 0, 0, 1, 0, 0);
    wr_en = 1'b1; din = 14'd77;
    @(posedge clk); #1;
    check("reset_edge_no_op", 1, 0, 0, 0, 1, 0, 0);
    #2 rst = 1'b0;
    wr_en = 1'b0;

    for (int i = 0; i < 35; i++) begin
      wr_en = tbl[i].wr; rd_en = tbl[i].rd; din = tbl[i].din;
      @(posedge clk); #1;
      check($sformatf("table[%0d]", i), tbl[i].chk_dout, tbl[i].dout, tbl[i].count,
            tbl[i].full, tbl[i].empty, tbl[i].ovf, tbl[i].udf);
    end
    q.delete();
    m_dout = 14'd15;

    // Sliding window: write every cycle, read from the 8th cycle on.
    for (int c = 0; c < 20; c++) step(1'b1, c >= 7, (c < 8) ? 14'd100 : 14'd200, "slide");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 14'd0, "slide_drain");

    // Simultaneous read/write with 5 stored, then with FIFO empty.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 14'(300 + i), "rw_fill");
    step(1'b1, 1'b1, 14'd310, "rw_at5");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 14'd0, "rw_drain");
    step(1'b1, 1'b1, 14'd320, "rw_empty");
    step(1'b0, 1'b1, 14'd0, "rw_pop");
    step(1'b0, 1'b0, 14'd0, "rw_idle");

    // 40 words with interleaved reads: both pointers wrap twice.
    n_wr = 0;
    for (int i = 0; i < 400 && !(n_wr == 40 && q.size() == 0); i++) begin
      w = (n_wr < 40) && (q.size() < 16);
      r = ((i % 4) != 0) || (n_wr >= 40);
      step(w, r, 14'(500 + n_wr), "wrap");
      if (w) n_wr++;
    end
    n_checks++;
    if (!(n_wr == 40 && q.size() == 0)) begin
      n_errors++;
      $display("FAIL wrap_done: got written=%0d left=%0d, expected written=40 left=0", n_wr, q.size());
    end

    // Reset mid-operation with 9 words stored.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 14'(600 + i), "pre_rst");
    #3 rst = 1'b1;
    #1 check("rst_mid", 1, 0, 0, 0, 1, 0, 0);
    wr_en = 1'b1; din = 14'd5;
    @(posedge clk); #1;
    check("rst_mid_edge", 1, 0, 0, 0, 1, 0, 0);
    #2 rst = 1'b0;
    wr_en = 1'b0;
    q.delete();
    m_dout = '0;
    step(1'b0, 1'b0, 14'd0, "post_rst_idle");
    step(1'b1, 1'b0, 14'h1ABC, "post_rst_write");
    step(1'b0, 1'b0, 14'd0, "post_rst_hold");
    step(1'b0, 1'b1, 14'd0, "post_rst_read");
    step(1'b0, 1'b0, 14'd0, "post_rst_end");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
